// File: rtl/fmap_stream_out.sv
// ---------------------------------------------------------------------------
// fmap_stream_out
//
// Purpose:
//    Sequential reader for the second convolution stage's parallel output
//    feature map. When start is accepted in IDLE, the whole map is copied into
//    an internal register bank. The copy is then streamed one element per beat
//    over a valid/ready handshake. Each beat carries its channel, row and column
//    indices and a last flag. A one-cycle done pulse follows the final accepted
//    beat.
//
// Ports:
//    clk         - clock, all logic on the rising edge
//    rst         - synchronous active-high reset
//    featuremap  - parallel signed map [CHANNELS][ROWS][COLS], sampled only on
//                  an accepted start
//    start       - request to capture and stream (ignored unless IDLE)
//    busy        - high while streaming
//    done        - one-cycle pulse after the final beat is accepted
//    out_valid   - beat on out_* is valid
//    out_ready   - downstream accepts the current beat
//    out_data    - element value, passed through unmodified
//    out_channel - channel index of out_data
//    out_row     - row index of out_data
//    out_col     - column index of out_data
//    out_last    - high on the final element (CHANNELS-1, ROWS-1, COLS-1)
// ---------------------------------------------------------------------------
module fmap_stream_out #(
   parameter int bitwidth = 16,
   parameter int CHANNELS = 2,
   parameter int ROWS     = 10,
   parameter int COLS     = 10,
   // Index widths are forced to at least one bit so a degenerate
   // dimension of size 1 still gives a legal port.
   localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
   localparam int ROW_W = (ROWS > 1)     ? $clog2(ROWS)     : 1,
   localparam int COL_W = (COLS > 1)     ? $clog2(COLS)     : 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic signed [bitwidth-1:0] featuremap [CHANNELS-1:0][ROWS-1:0][COLS-1:0],
   input  logic                       start,
   output logic                       busy,
   output logic                       done,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic signed [bitwidth-1:0] out_data,
   output logic [CH_W-1:0]            out_channel,
   output logic [ROW_W-1:0]           out_row,
   output logic [COL_W-1:0]           out_col,
   output logic                       out_last
);

   // FSM state encoding
   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_STREAM = 2'd1;
   localparam logic [1:0] S_DONE   = 2'd2;

   // Terminal index values for each counter
   localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(CHANNELS - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);

   logic [1:0]                r_state;
   logic [CH_W-1:0]           r_ch;
   logic [ROW_W-1:0]          r_row;
   logic [COL_W-1:0]          r_col;
   logic signed [bitwidth-1:0] r_snap [CHANNELS-1:0][ROWS-1:0][COLS-1:0];

   logic w_streaming;
   logic w_capture;
   logic w_transfer;
   logic w_colEnd;
   logic w_rowEnd;
   logic w_chEnd;
   logic w_lastBeat;

   // Decode the handshake and index-wrap conditions that steer the FSM
   // and the counters.
   assign w_streaming = (r_state == S_STREAM);
   assign w_capture   = (r_state == S_IDLE) && start;
   assign w_transfer  = w_streaming && out_ready;
   assign w_colEnd    = (r_col == COL_LAST);
   assign w_rowEnd    = (r_row == ROW_LAST);
   assign w_chEnd     = (r_ch == CH_LAST);
   assign w_lastBeat  = w_colEnd && w_rowEnd && w_chEnd;

   // Snapshot bank. It is not reset because its contents are only read
   // after a capture has refreshed every entry.
   always_ff @(posedge clk) begin
      if (!rst && w_capture) begin
         r_snap <= featuremap;
      end
   end

   // Control FSM and element counters. The counters walk channel-major,
   // then row, then column. They return to zero on capture, on reset and
   // after the final beat, so the index outputs read zero while idle.
   // A stall simply leaves every register alone, which keeps all out_*
   // signals stable until the beat transfers.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_ch    <= '0;
         r_row   <= '0;
         r_col   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_state <= S_STREAM;
                  r_ch    <= '0;
                  r_row   <= '0;
                  r_col   <= '0;
               end
            end
            S_STREAM: begin
               if (w_transfer) begin
                  if (w_lastBeat) begin
                     r_state <= S_DONE;
                     r_ch    <= '0;
                     r_row   <= '0;
                     r_col   <= '0;
                  end else if (w_colEnd) begin
                     r_col <= '0;
                     if (w_rowEnd) begin
                        r_row <= '0;
                        r_ch  <= r_ch + CH_W'(1);
                     end else begin
                        r_row <= r_row + ROW_W'(1);
                     end
                  end else begin
                     r_col <= r_col + COL_W'(1);
                  end
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // Output decode. Data is forced to zero outside STREAM so that reset
   // and idle show a clean zero, independent of the unreset snapshot.
   assign busy        = w_streaming;
   assign out_valid   = w_streaming;
   assign done        = (r_state == S_DONE);
   assign out_last    = w_streaming && w_lastBeat;
   assign out_data    = w_streaming ? r_snap[r_ch][r_row][r_col] : '0;
   assign out_channel = r_ch;
   assign out_row     = r_row;
   assign out_col     = r_col;

endmodule

// File: tb/tb_fmap_stream_out.sv
// ---------------------------------------------------------------------------
// tb_fmap_stream_out
//
// Purpose:
//    Self-checking bench for fmap_stream_out. A behavioural model tracks only
//    "streaming or not", "done pulse pending" and a flat beat number k in the
//    range 0..199. It derives the expected element and indices from k with
//    plain division and modulo. A negedge process compares every output against
//    the model on every cycle. Literal expectations on the collected beats pin
//    the model itself.
// ---------------------------------------------------------------------------
module tb_fmap_stream_out;

   localparam int CH     = 2;
   localparam int RW     = 10;
   localparam int CL     = 10;
   localparam int NBEATS = CH * RW * CL;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic                start = 1'b0;
   logic                outReady = 1'b1;
   logic signed [15:0]  fm [1:0][9:0][9:0];
   logic                busy;
   logic                done;
   logic                outValid;
   logic signed [15:0]  outData;
   logic [0:0]          outChannel;
   logic [3:0]          outRow;
   logic [3:0]          outCol;
   logic                outLast;

   int  errors = 0;
   int  checks = 0;
   bit  checkEn = 1'b0;
   int  readyMode = 0;
   int  cyc = 0;
   int  accQ [$];
   int  doneCount = 0;

   // Reference model state
   bit  mBusy = 1'b0;
   bit  mDone = 1'b0;
   int  mK = 0;
   int  mSnap [NBEATS];

   fmap_stream_out #(
      .bitwidth(16), .CHANNELS(CH), .ROWS(RW), .COLS(CL)
   ) dut (
      .clk(clk), .rst(rst), .featuremap(fm), .start(start),
      .busy(busy), .done(done), .out_valid(outValid), .out_ready(outReady),
      .out_data(outData), .out_channel(outChannel), .out_row(outRow),
      .out_col(outCol), .out_last(outLast)
   );

   always #5 clk = ~clk;

   // Compare one value and report a mismatch.
   task automatic checkOutput(input string name, input logic signed [31:0] act,
                              input logic signed [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Drive start/rst and advance n cycles, landing just after a rising edge.
   task automatic applyStimulus(input logic st, input logic rs, input int n);
      start = st;
      rst   = rs;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic waitBeats(input int n);
      int cnt = 0;
      start = 1'b0;
      while (accQ.size() < n && cnt < 3000) begin
         @(posedge clk);
         #1;
         cnt++;
      end
      if (cnt >= 3000) checkOutput("beatTimeout", accQ.size(), n);
   endtask

   task automatic waitDone();
      int cnt = 0;
      start = 1'b0;
      while (!done && cnt < 3000) begin
         @(posedge clk);
         #1;
         cnt++;
      end
      if (cnt >= 3000) checkOutput("doneTimeout", 0, 1);
   endtask

   task automatic setRamp();
      for (int c = 0; c < CH; c++)
         for (int r = 0; r < RW; r++)
            for (int k = 0; k < CL; k++)
               fm[c][r][k] = 16'(c * 100 + r * 10 + k);
   endtask

   task automatic setRandom();
      for (int c = 0; c < CH; c++)
         for (int r = 0; r < RW; r++)
            for (int k = 0; k < CL; k++)
               fm[c][r][k] = 16'($urandom);
   endtask

   task automatic setZero();
      for (int c = 0; c < CH; c++)
         for (int r = 0; r < RW; r++)
            for (int k = 0; k < CL; k++)
               fm[c][r][k] = 16'sd0;
   endtask

   // Check the collected stream against hand-computed element values.
   task automatic checkRampStream(input string tag);
      checkOutput({tag, "Count"}, accQ.size(), NBEATS);
      checkOutput({tag, "DoneCount"}, doneCount, 1);
      if (accQ.size() == NBEATS) begin
         checkOutput({tag, "Beat0"}, accQ[0], 0);
         checkOutput({tag, "Beat37"}, accQ[37], 37);
         checkOutput({tag, "Beat100"}, accQ[100], 100);
         checkOutput({tag, "Beat199"}, accQ[199], 199);
      end
   endtask

   // Behavioural model: a beat number k advances on each accepted beat. The
   // snapshot is a flat copy taken when start is seen while idle.
   always @(posedge clk) begin
      if (rst) begin
         mBusy <= 1'b0;
         mDone <= 1'b0;
         mK    <= 0;
      end else if (mDone) begin
         mDone <= 1'b0;
      end else if (!mBusy) begin
         if (start) begin
            for (int c = 0; c < CH; c++)
               for (int r = 0; r < RW; r++)
                  for (int k = 0; k < CL; k++)
                     mSnap[c * RW * CL + r * CL + k] <= int'(fm[c][r][k]);
            mBusy <= 1'b1;
            mK    <= 0;
         end
      end else if (outReady) begin
         if (mK == NBEATS - 1) begin
            mBusy <= 1'b0;
            mDone <= 1'b1;
            mK    <= 0;
         end else begin
            mK <= mK + 1;
         end
      end
   end

   // Ready pattern generator: 0 = always ready, 1 = 1,0,0,1 repeating, 2 = random.
   always @(posedge clk) begin
      #1;
      cyc++;
      case (readyMode)
         0: outReady = 1'b1;
         1: outReady = ((cyc % 4) == 0) || ((cyc % 4) == 3);
         default: outReady = 1'($urandom_range(0, 1));
      endcase
   end

   // Per-cycle comparison against the model, plus beat and done collection.
   always @(negedge clk) begin
      if (checkEn) begin
         checkOutput("busy", busy, mBusy);
         checkOutput("valid", outValid, mBusy);
         checkOutput("done", done, mDone);
         checkOutput("last", outLast, mBusy && (mK == NBEATS - 1));
         if (mBusy) begin
            checkOutput("data", outData, mSnap[mK]);
            checkOutput("channel", outChannel, mK / (RW * CL));
            checkOutput("row", outRow, (mK / CL) % RW);
            checkOutput("col", outCol, mK % CL);
         end
         if (outValid && outReady && !rst) accQ.push_back(int'(outData));
         if (done) doneCount++;
      end
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      setZero();

      // Reset then idle
      applyStimulus(0, 1, 2);
      checkEn = 1'b1;
      checkOutput("rstBusy", busy, 0);
      checkOutput("rstValid", outValid, 0);
      checkOutput("rstDone", done, 0);
      checkOutput("rstLast", outLast, 0);
      checkOutput("rstData", outData, 0);
      checkOutput("rstChannel", outChannel, 0);
      checkOutput("rstRow", outRow, 0);
      checkOutput("rstCol", outCol, 0);
      applyStimulus(0, 0, 8);
      checkOutput("idleBusy", busy, 0);
      checkOutput("idleValid", outValid, 0);

      // Full stream, always ready
      $display("[TB] full stream");
      readyMode = 0;
      setRamp();
      accQ.delete();
      doneCount = 0;
      applyStimulus(1, 0, 1);
      checkOutput("firstValid", outValid, 1);
      checkOutput("firstData", outData, 0);
      waitDone();
      applyStimulus(0, 0, 3);
      checkRampStream("full");

      // Backpressure 1,0,0,1
      $display("[TB] backpressure");
      readyMode = 1;
      accQ.delete();
      doneCount = 0;
      applyStimulus(1, 0, 1);
      waitDone();
      applyStimulus(0, 0, 3);
      checkRampStream("bp");

      // Snapshot isolation with sign extremes
      $display("[TB] snapshot isolation");
      readyMode = 2;
      setRandom();
      fm[0][0][0] = -16'sd32768;
      fm[1][9][9] = -16'sd1;
      accQ.delete();
      doneCount = 0;
      applyStimulus(1, 0, 1);
      setZero();
      waitDone();
      applyStimulus(0, 0, 3);
      checkOutput("snapModel0", mSnap[0], -32768);
      checkOutput("snapCount", accQ.size(), NBEATS);
      if (accQ.size() == NBEATS) begin
         checkOutput("snapBeat0", accQ[0], -32768);
         checkOutput("snapBeat199", accQ[199], -1);
      end

      // Start while busy and during the done cycle
      $display("[TB] start while busy");
      readyMode = 0;
      setRamp();
      accQ.delete();
      doneCount = 0;
      applyStimulus(1, 0, 1);
      waitBeats(5);
      applyStimulus(1, 0, 1);
      waitBeats(150);
      applyStimulus(1, 0, 1);
      waitDone();
      applyStimulus(1, 0, 1);
      applyStimulus(0, 0, 5);
      checkOutput("restartIdleBusy", busy, 0);
      checkRampStream("busyStart");
      accQ.delete();
      doneCount = 0;
      applyStimulus(1, 0, 1);
      waitDone();
      applyStimulus(0, 0, 3);
      checkRampStream("fresh");

      // Reset mid-stream
      $display("[TB] reset mid-stream");
      readyMode = 2;
      setRandom();
      accQ.delete();
      doneCount = 0;
      applyStimulus(1, 0, 1);
      waitBeats(57);
      applyStimulus(0, 1, 1);
      checkOutput("abortValid", outValid, 0);
      checkOutput("abortBusy", busy, 0);
      applyStimulus(0, 0, 10);
      checkOutput("abortDoneCount", doneCount, 0);
      accQ.delete();
      applyStimulus(1, 0, 1);
      waitDone();
      applyStimulus(0, 0, 3);
      checkOutput("afterAbortCount", accQ.size(), NBEATS);
      if (accQ.size() == NBEATS) begin
         checkOutput("afterAbortBeat0", accQ[0], int'(fm[0][0][0]));
         checkOutput("afterAbortBeat199", accQ[199], int'(fm[1][9][9]));
      end

      checkEn = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
